slice_header_parser: RTL and testbench
======================================

# slice_header_parser

Decoder-side counterpart of the slice header emitter. Consumes the byte-aligned slice header at the head of each coded slice and extracts the header size, reserved bits, qscale, Y component size and Cb component size for the slice decoder. Sits between the slice byte fetcher and the coefficient/entropy decode stages. Extra header bytes beyond the minimum are skipped.

## Interface

Parameters:
- MIN_HDR_BYTES, 6, smallest legal header size in bytes. Also the number of bytes this block parses.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin parsing a new header. Honoured only in IDLE.
- in_valid  input  1  in_data carries a header byte.
- in_data  input  8  header byte, MSB-first bit order.
- in_ready  output  1  block accepts a byte this cycle.
- busy  output  1  state is not IDLE.
- hdr_valid  output  1  one-cycle pulse: all field outputs are valid.
- error  output  1  one-cycle pulse: illegal header size. No hdr_valid is produced.
- hdr_size  output  5  header size in bytes, from byte0[7:3].
- reserved  output  3  byte0[2:0]. Captured only; not checked.
- qscale  output  8  byte1.
- y_size  output  16  {byte2, byte3}, big-endian.
- cb_size  output  16  {byte4, byte5}, big-endian.

## Operation

- A byte is accepted in a cycle when in_valid && in_ready.
- in_ready = 1 only in states B0, B1, B2, B3, B4, B5 and SKIP. It is a registered function of state and does not depend on in_valid.
- States and transitions:
  - IDLE: if start, go to B0.
  - B0: on accept, capture hdr_size and reserved.
    - If in_data[7:3] < MIN_HDR_BYTES, go to ERR.
    - Otherwise go to B1.
  - B1: on accept, capture qscale. Go to B2.
  - B2: on accept, capture y_size[15:8]. Go to B3.
  - B3: on accept, capture y_size[7:0]. Go to B4.
  - B4: on accept, capture cb_size[15:8]. Go to B5.
  - B5: on accept, capture cb_size[7:0].
    - If skip_cnt == 0, go to DONE.
    - Otherwise go to SKIP.
  - SKIP: each accept decrements skip_cnt. When an accept occurs with skip_cnt == 1, go to DONE.
  - DONE: hdr_valid = 1 for this single cycle. Go to IDLE.
  - ERR: error = 1 for this single cycle. Go to IDLE.
- skip_cnt is 5 bits and is loaded in B0 with in_data[7:3] − MIN_HDR_BYTES. Its range is 0..25. Subtraction happens only when the size is legal, so it never wraps.
- Without in_valid, any Bx/SKIP state holds indefinitely. No timeout.
- Field outputs hold their last captured values until overwritten by a later capture. A new start does not clear them.
- After an error, fields captured before the error (hdr_size, reserved) remain visible. The others keep their previous values.
- start outside IDLE is ignored, including start coincident with the DONE or ERR cycle.
- start in IDLE with in_valid high in the same cycle: no byte is accepted that cycle, because in_ready = 0 in IDLE.

## Timing

- Reset values: all outputs 0, state IDLE, skip_cnt 0. Assertion of reset_n mid-parse aborts immediately, with no hdr_valid and no error pulse.
- start sampled high at edge N: in_ready = 1 from cycle N+1.
- Latency: with continuous in_valid, a header of hdr_size bytes starting at cycle N+1 produces hdr_valid in cycle N+1+hdr_size. Minimum start-to-start period is hdr_size+2 cycles.
- Illegal size byte accepted at cycle M: error = 1 in cycle M+1, and busy = 0 from cycle M+2.
- busy = 1 from cycle N+1 through the DONE/ERR cycle inclusive.

## Test plan

- Nominal header: start, then bytes 0x30, 0x04, 0x03, 0x19, 0x00, 0x7C back-to-back.
  - Expect hdr_valid exactly 7 cycles after start is sampled.
  - Expect hdr_size=6, reserved=0, qscale=4, y_size=0x0319, cb_size=0x007C.
  - Expect in_ready low in the DONE cycle.
- Back-pressure gaps: same bytes, in_valid deasserted for 3 cycles between each byte.
  - Identical field values.
  - hdr_valid 1 cycle after the 6th accept.
  - No extra bytes consumed.
- Extended header: byte0=0x40 (size 8), then 0x10, 0x01, 0x00, 0x00, 0x80, 0xAA, 0xBB.
  - All 8 bytes are accepted.
  - qscale=0x10, y_size=0x0100, cb_size=0x0080.
  - hdr_valid follows the 8th byte. The 9th byte offered is not accepted.
- Illegal size: byte0=0x2F (size 5, reserved 7).
  - error pulse 1 cycle after the accept; no hdr_valid.
  - hdr_size=5, reserved=7; qscale, y_size and cb_size unchanged.
  - A subsequent nominal header parses correctly.
- Reset mid-parse: assert reset_n low after byte 3 of the nominal header.
  - All outputs read 0 immediately and busy=0.
  - After release, a full nominal header parses correctly.
- Spurious start: start pulses while in B2 and in the DONE cycle.
  - Both are ignored; parse results are unaffected.
  - busy drops after DONE and no second parse begins.

Source files
------------

// File: rtl/slice_header_parser.sv
// Slice header parser: pulls the fixed six-byte slice header off the byte stream
// and skips any extra header bytes.
module slice_header_parser #(
   parameter int MIN_HDR_BYTES = 6
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        busy,
   output logic        hdr_valid,
   output logic        error,
   output logic [4:0]  hdr_size,
   output logic [2:0]  reserved,
   output logic [7:0]  qscale,
   output logic [15:0] y_size,
   output logic [15:0] cb_size
);

   localparam logic [4:0] MIN_SIZE = 5'(MIN_HDR_BYTES);

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      B0   = 4'd1,
      B1   = 4'd2,
      B2   = 4'd3,
      B3   = 4'd4,
      B4   = 4'd5,
      B5   = 4'd6,
      SKIP = 4'd7,
      DONE = 4'd8,
      ERR  = 4'd9
   } state_t;

   state_t      state_r;
   state_t      next_s;
   logic [4:0]  skip_cnt_r;
   logic [4:0]  skip_next_s;
   logic        accept_s;
   logic        next_rdy_s;

   // in_ready is registered, so it is already a pure function of state_r
   assign accept_s = in_valid && in_ready;

   // State and skip counter register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         skip_cnt_r <= 5'd0;
      end else begin
         state_r    <= next_s;
         skip_cnt_r <= skip_next_s;
      end
   end

   // Next-state and skip counter logic
   always_comb begin
      next_s      = state_r;
      skip_next_s = skip_cnt_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               next_s = B0;
            end else begin
               next_s = IDLE;
            end
         end
         B0: begin
            if (accept_s) begin
               if (in_data[7:3] < MIN_SIZE) begin
                  next_s = ERR;
               end else begin
                  next_s      = B1;
                  skip_next_s = in_data[7:3] - MIN_SIZE;
               end
            end else begin
               next_s = B0;
            end
         end
         B1: begin
            if (accept_s) next_s = B2;
            else          next_s = B1;
         end
         B2: begin
            if (accept_s) next_s = B3;
            else          next_s = B2;
         end
         B3: begin
            if (accept_s) next_s = B4;
            else          next_s = B3;
         end
         B4: begin
            if (accept_s) next_s = B5;
            else          next_s = B4;
         end
         B5: begin
            if (accept_s) begin
               if (skip_cnt_r == 5'd0) next_s = DONE;
               else                    next_s = SKIP;
            end else begin
               next_s = B5;
            end
         end
         SKIP: begin
            if (accept_s) begin
               skip_next_s = skip_cnt_r - 5'd1;
               if (skip_cnt_r == 5'd1) next_s = DONE;
               else                    next_s = SKIP;
            end else begin
               next_s = SKIP;
            end
         end
         DONE:    next_s = IDLE;
         ERR:     next_s = IDLE;
         default: next_s = IDLE;
      endcase
   end

   // Byte-accepting states, evaluated on the next state so in_ready can be registered
   always_comb begin
      case (next_s)
         B0, B1, B2, B3, B4, B5, SKIP: next_rdy_s = 1'b1;
         default:                      next_rdy_s = 1'b0;
      endcase
   end

   // Status outputs registered from the next state so they line up with state_r
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         hdr_valid <= 1'b0;
         error     <= 1'b0;
      end else begin
         in_ready  <= next_rdy_s;
         busy      <= (next_s != IDLE);
         hdr_valid <= (next_s == DONE);
         error     <= (next_s == ERR);
      end
   end

   // Field capture; fields persist across headers until overwritten
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hdr_size <= 5'd0;
         reserved <= 3'd0;
         qscale   <= 8'd0;
         y_size   <= 16'd0;
         cb_size  <= 16'd0;
      end else if (accept_s) begin
         case (state_r)
            B0: begin
               hdr_size <= in_data[7:3];
               reserved <= in_data[2:0];
            end
            B1:      qscale        <= in_data;
            B2:      y_size[15:8]  <= in_data;
            B3:      y_size[7:0]   <= in_data;
            B4:      cb_size[15:8] <= in_data;
            B5:      cb_size[7:0]  <= in_data;
            default: hdr_size      <= hdr_size;
         endcase
      end else begin
         hdr_size <= hdr_size;
      end
   end

endmodule

// File: tb/tb_slice_header_parser.sv
// Self-checking bench for slice_header_parser: directed header scenarios plus
// randomized headers checked against a field-level model.
module tb_slice_header_parser;

   localparam int MIN_HDR_BYTES = 6;

   typedef logic [7:0] byte_q_t [$];

   logic        clock;
   logic        reset_n;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        busy;
   logic        hdr_valid;
   logic        error;
   logic [4:0]  hdr_size;
   logic [2:0]  reserved;
   logic [7:0]  qscale;
   logic [15:0] y_size;
   logic [15:0] cb_size;

   int n_checks;
   int n_pass;

   logic [4:0]  exp_size;
   logic [2:0]  exp_res;
   logic [7:0]  exp_q;
   logic [15:0] exp_y;
   logic [15:0] exp_cb;

   slice_header_parser #(.MIN_HDR_BYTES(MIN_HDR_BYTES)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .busy      (busy),
      .hdr_valid (hdr_valid),
      .error     (error),
      .hdr_size  (hdr_size),
      .reserved  (reserved),
      .qscale    (qscale),
      .y_size    (y_size),
      .cb_size   (cb_size)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_fields(input string tag);
      check_val({tag, ".hdr_size"}, 32'(hdr_size), 32'(exp_size));
      check_val({tag, ".reserved"}, 32'(reserved), 32'(exp_res));
      check_val({tag, ".qscale"},   32'(qscale),   32'(exp_q));
      check_val({tag, ".y_size"},   32'(y_size),   32'(exp_y));
      check_val({tag, ".cb_size"},  32'(cb_size),  32'(exp_cb));
   endtask

   task automatic check_status(input string tag, input logic rdy, input logic bsy,
                               input logic hv, input logic er);
      check_val({tag, ".in_ready"},  32'(in_ready),  32'(rdy));
      check_val({tag, ".busy"},      32'(busy),      32'(bsy));
      check_val({tag, ".hdr_valid"}, 32'(hdr_valid), 32'(hv));
      check_val({tag, ".error"},     32'(error),     32'(er));
   endtask

   task automatic model_reset();
      exp_size = 5'd0;
      exp_res  = 3'd0;
      exp_q    = 8'd0;
      exp_y    = 16'd0;
      exp_cb   = 16'd0;
   endtask

   // Drive one header. The model decides how many bytes must be consumed and
   // in which cycle the result pulse appears; the DUT is checked cycle by cycle.
   task automatic run_header(input string tag, input byte_q_t hdr, input int gap_min,
                             input int gap_max, input logic spurious, input int abort_after);
      logic [7:0] b0;
      int         size;
      logic       legal;
      int         needed;
      int         gaps;
      b0     = hdr[0];
      size   = int'(b0[7:3]);
      legal  = (size >= MIN_HDR_BYTES);
      needed = legal ? size : 1;

      @(negedge clock);
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(negedge clock);
      start = 1'b0;
      for (int i = 0; i < needed; i++) begin
         if (abort_after == i) begin
            reset_n  = 1'b0;
            in_valid = 1'b0;
            #1;
            model_reset();
            check_status({tag, ".abort"}, 1'b0, 1'b0, 1'b0, 1'b0);
            check_fields({tag, ".abort"});
            @(negedge clock);
            reset_n = 1'b1;
            return;
         end
         gaps = (i == 0) ? 0 : int'($urandom_range(gap_max, gap_min));
         for (int g = 0; g < gaps; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            check_status({tag, ".gap"}, 1'b1, 1'b1, 1'b0, 1'b0);
            @(negedge clock);
         end
         in_valid = 1'b1;
         in_data  = hdr[i];
         start    = spurious && (i == 2);
         check_status({tag, ".byte"}, 1'b1, 1'b1, 1'b0, 1'b0);
         @(negedge clock);
         start = 1'b0;
      end

      exp_size = b0[7:3];
      exp_res  = b0[2:0];
      if (legal) begin
         exp_q  = hdr[1];
         exp_y  = {hdr[2], hdr[3]};
         exp_cb = {hdr[4], hdr[5]};
      end

      // Result cycle: an extra byte stays offered and must not be taken
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      start    = spurious;
      check_status({tag, ".result"}, 1'b0, 1'b1, legal, !legal);
      check_fields({tag, ".result"});
      @(negedge clock);
      start = 1'b0;
      check_status({tag, ".after1"}, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      in_valid = 1'b0;
      check_status({tag, ".after2"}, 1'b0, 1'b0, 1'b0, 1'b0);
      check_fields({tag, ".after2"});
   endtask

   byte_q_t nominal;
   byte_q_t hq;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset_n  = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'd0;
      model_reset();
      nominal = '{8'h30, 8'h04, 8'h03, 8'h19, 8'h00, 8'h7C};

      #1;
      check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      check_fields("reset");
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check_status("idle", 1'b0, 1'b0, 1'b0, 1'b0);

      run_header("nominal", nominal, 0, 0, 1'b0, -1);
      run_header("gaps", nominal, 3, 3, 1'b0, -1);
      hq = '{8'h40, 8'h10, 8'h01, 8'h00, 8'h00, 8'h80, 8'hAA, 8'hBB};
      run_header("extended", hq, 0, 0, 1'b0, -1);
      hq = '{8'h2F};
      run_header("illegal", hq, 0, 0, 1'b0, -1);
      run_header("post_err", nominal, 0, 0, 1'b0, -1);
      run_header("abort", nominal, 0, 0, 1'b0, 3);
      run_header("post_abort", nominal, 0, 0, 1'b0, -1);
      run_header("spurious", nominal, 0, 1, 1'b1, -1);

      for (int t = 0; t < 40; t++) begin
         int size;
         if ($urandom_range(3, 0) == 0) size = int'($urandom_range(5, 0));
         else                           size = int'($urandom_range(31, 6));
         hq = {};
         hq.push_back({5'(size), 3'($urandom)});
         for (int k = 1; k < 32; k++) hq.push_back(8'($urandom));
         run_header("random", hq, 0, 2, 1'($urandom), -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
